// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// latches the returned word into the IF/ID register, with redirect, stall, flush and halt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [29:0] LP_MEM_WORDS = 30'(MEM_WORDS);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_halted;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_pc;
    logic [31:0] w_branch_pc;
    logic        w_out_of_range;
    logic        w_unused_bt_lsb;

    assign w_pc_plus4      = r_pc + 32'd4;
    // Jump keeps the region bits of the jump's own PC+4, which sits in IF/ID.
    assign w_jump_pc       = {r_pc4[31:28], jump_index, 2'b00};
    assign w_branch_pc     = {branch_target[31:2], 2'b00};
    assign w_out_of_range  = (r_pc[31:2] >= LP_MEM_WORDS);
    assign w_unused_bt_lsb = &{1'b0, branch_target[1:0]};

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_pc     <= {RESET_PC[31:2], 2'b00};
            r_instr  <= 32'd0;
            r_pc4    <= 32'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        if (jump || branch_taken) begin
                            r_pc    <= jump ? w_jump_pc : w_branch_pc;
                            r_instr <= 32'd0;
                            r_pc4   <= 32'd0;
                            r_valid <= 1'b0;
                        end else if (w_out_of_range) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                            r_instr  <= 32'd0;
                            r_pc4    <= 32'd0;
                            r_valid  <= 1'b0;
                        end else begin
                            r_pc <= w_pc_plus4;
                            if (flush) begin
                                r_instr <= 32'd0;
                                r_pc4   <= 32'd0;
                                r_valid <= 1'b0;
                            end else begin
                                r_instr <= imem_instr;
                                r_pc4   <= w_pc_plus4;
                                r_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // Frozen until reset; every hazard and redirect input is ignored.
                    r_valid  <= 1'b0;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign halted      = r_halted;

endmodule
